// File: rtl/alu_seq.sv
// alu_seq: micro-sequencer driving an external 8-bit adder-style ALU.
// Runs 8- or 16-bit ADD/ADC/SUB/SBC/INC/DEC as one or two byte passes,
// chains carry from the low byte into the high byte, and owns the
// architectural status flags {C,Z,N,V}. CLC/SEC touch only C.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req, cmd, wide        command request (sampled in IDLE), opcode, 16-bit select
//   opa, opb              operands, captured when the command is accepted
//   busy, done            busy outside IDLE; done is a one-cycle completion pulse
//   res                   result, held until the next completion
//   flag_c/z/n/v          status register
//   alu_op/ai/bi/ci       ALU operation and operands (op is always add-with-carry)
//   alu_out/c/z/n/v       ALU result and flags
module alu_seq #(
    parameter logic [3:0] STATUS_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  cmd,
    input  logic        wide,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] res,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_v,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_ai,
    output logic [7:0]  alu_bi,
    output logic        alu_ci,
    input  logic [7:0]  alu_out,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_ADC = 3'b001;
    localparam logic [2:0] CMD_SUB = 3'b010;
    localparam logic [2:0] CMD_SBC = 3'b011;
    localparam logic [2:0] CMD_INC = 3'b100;
    localparam logic [2:0] CMD_DEC = 3'b101;
    localparam logic [2:0] CMD_CLC = 3'b110;
    localparam logic [2:0] CMD_SEC = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Captured command and high operand bytes (low bytes go straight to the ALU regs)
    logic [2:0]        cmd_q,   cmd_d;
    logic              wide_q,  wide_d;
    logic [BYTE_W-1:0] opa_hi_q, opa_hi_d;
    logic [BYTE_W-1:0] opb_hi_q, opb_hi_d;

    // Low-pass results kept for the high pass
    logic [BYTE_W-1:0] lo_q,    lo_d;
    logic              carry_q, carry_d;
    logic              zero_q,  zero_d;

    // Next values of the registered outputs
    logic              busy_d, done_d;
    logic [WORD_W-1:0] res_d;
    logic              flag_c_d, flag_z_d, flag_n_d, flag_v_d;
    logic [BYTE_W-1:0] alu_ai_d, alu_bi_d;
    logic              alu_ci_d;

    // B-side byte for a pass; subtraction feeds the inverted operand
    function automatic logic [BYTE_W-1:0] map_b(input logic [2:0] c, input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] r;
        r = 8'h00;
        case (c)
            CMD_ADD, CMD_ADC: r = b;
            CMD_SUB, CMD_SBC: r = ~b;
            CMD_INC:          r = 8'h00;
            CMD_DEC:          r = 8'hFF;
            default:          r = 8'h00;
        endcase
        return r;
    endfunction

    // Carry-in for the low pass; C=1 means "no borrow" for subtraction
    function automatic logic map_ci(input logic [2:0] c, input logic sc);
        logic r;
        r = 1'b0;
        case (c)
            CMD_ADD: r = 1'b0;
            CMD_ADC: r = sc;
            CMD_SUB: r = 1'b1;
            CMD_SBC: r = sc;
            CMD_INC: r = 1'b1;
            CMD_DEC: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign alu_op = 2'b00;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = ((cmd == CMD_CLC) || (cmd == CMD_SEC)) ? S_FIN : S_LO;
                end
            end
            S_LO:    state_d = wide_q ? S_HI : S_FIN;
            S_HI:    state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cmd_d    = cmd_q;
        wide_d   = wide_q;
        opa_hi_d = opa_hi_q;
        opb_hi_d = opb_hi_q;
        lo_d     = lo_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        res_d    = res;
        flag_c_d = flag_c;
        flag_z_d = flag_z;
        flag_n_d = flag_n;
        flag_v_d = flag_v;
        alu_ai_d = alu_ai;
        alu_bi_d = alu_bi;
        alu_ci_d = alu_ci;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_FIN);

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cmd_d    = cmd;
                    wide_d   = wide;
                    opa_hi_d = opa[15:8];
                    opb_hi_d = opb[15:8];
                    if (cmd == CMD_CLC) begin
                        flag_c_d = 1'b0;
                    end else if (cmd == CMD_SEC) begin
                        flag_c_d = 1'b1;
                    end else begin
                        alu_ai_d = opa[7:0];
                        alu_bi_d = map_b(cmd, opb[7:0]);
                        alu_ci_d = map_ci(cmd, flag_c);
                    end
                end
            end
            S_LO: begin
                lo_d    = alu_out;
                carry_d = alu_c;
                zero_d  = alu_z;
                if (wide_q) begin
                    // Set up the high pass, chaining the low-byte carry
                    alu_ai_d = opa_hi_q;
                    alu_bi_d = map_b(cmd_q, opb_hi_q);
                    alu_ci_d = alu_c;
                end else begin
                    res_d    = {8'h00, alu_out};
                    flag_c_d = alu_c;
                    flag_z_d = alu_z;
                    flag_n_d = alu_n;
                    flag_v_d = alu_v;
                end
            end
            S_HI: begin
                res_d    = {alu_out, lo_q};
                flag_c_d = alu_c;
                flag_z_d = zero_q & alu_z;
                flag_n_d = alu_n;
                flag_v_d = alu_v;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= CMD_ADD;
            wide_q   <= 1'b0;
            opa_hi_q <= 8'h00;
            opb_hi_q <= 8'h00;
            lo_q     <= 8'h00;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res      <= 16'h0000;
            flag_c   <= STATUS_RST[3];
            flag_z   <= STATUS_RST[2];
            flag_n   <= STATUS_RST[1];
            flag_v   <= STATUS_RST[0];
            alu_ai   <= 8'h00;
            alu_bi   <= 8'h00;
            alu_ci   <= 1'b0;
        end else begin
            cmd_q    <= cmd_d;
            wide_q   <= wide_d;
            opa_hi_q <= opa_hi_d;
            opb_hi_q <= opb_hi_d;
            lo_q     <= lo_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            busy     <= busy_d;
            done     <= done_d;
            res      <= res_d;
            flag_c   <= flag_c_d;
            flag_z   <= flag_z_d;
            flag_n   <= flag_n_d;
            flag_v   <= flag_v_d;
            alu_ai   <= alu_ai_d;
            alu_bi   <= alu_bi_d;
            alu_ci   <= alu_ci_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural 8-bit ALU on the ALU port, a word-level
// arithmetic model of the expected result and flags, directed cases and
// a randomized command stream.
module tb_alu_seq;

    localparam logic [3:0] STATUS_RST = 4'b0000;

    localparam logic [2:0] ADD = 3'd0, ADC = 3'd1, SUB = 3'd2, SBC = 3'd3;
    localparam logic [2:0] INC = 3'd4, DEC = 3'd5, CLC = 3'd6, SEC = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [2:0]  cmd;
    logic        wide;
    logic [15:0] opa, opb;
    logic        busy, done;
    logic [15:0] res;
    logic        flag_c, flag_z, flag_n, flag_v;
    logic [1:0]  alu_op;
    logic [7:0]  alu_ai, alu_bi;
    logic        alu_ci;
    logic [7:0]  alu_out;
    logic        alu_c, alu_z, alu_n, alu_v;
    logic [8:0]  alu_sum;

    int checks = 0;
    int failures = 0;

    // Expected architectural state
    logic [15:0] m_res;
    logic        m_c, m_z, m_n, m_v;

    always #5 clk = ~clk;

    alu_seq #(.STATUS_RST(STATUS_RST)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .wide(wide),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .res(res),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .alu_op(alu_op), .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v)
    );

    // 8-bit add-with-carry ALU
    assign alu_sum = 9'(alu_ai) + 9'(alu_bi) + 9'(alu_ci);
    assign alu_out = alu_sum[7:0];
    assign alu_c   = alu_sum[8];
    assign alu_z   = (alu_sum[7:0] == 8'h00);
    assign alu_n   = alu_sum[7];
    assign alu_v   = (alu_ai[7] == alu_bi[7]) && (alu_sum[7] != alu_ai[7]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: A + B' + cin over the operation width
    function automatic void model_apply(input logic [2:0] c, input logic w,
                                        input logic [15:0] a, input logic [15:0] b);
        logic [15:0] bb;
        logic        ci;
        logic [16:0] s;
        logic [8:0]  s8;
        bb = 16'h0000;
        ci = 1'b0;
        case (c)
            ADD: begin bb = b;        ci = 1'b0; end
            ADC: begin bb = b;        ci = m_c;  end
            SUB: begin bb = ~b;       ci = 1'b1; end
            SBC: begin bb = ~b;       ci = m_c;  end
            INC: begin bb = 16'h0000; ci = 1'b1; end
            DEC: begin bb = 16'hFFFF; ci = 1'b0; end
            default: begin bb = 16'h0000; ci = 1'b0; end
        endcase
        if (c == CLC) begin
            m_c = 1'b0;
        end else if (c == SEC) begin
            m_c = 1'b1;
        end else if (w) begin
            s     = 17'(a) + 17'(bb) + 17'(ci);
            m_res = s[15:0];
            m_c   = s[16];
            m_z   = (s[15:0] == 16'h0000);
            m_n   = s[15];
            m_v   = (a[15] == bb[15]) && (s[15] != a[15]);
        end else begin
            s8    = 9'(a[7:0]) + 9'(bb[7:0]) + 9'(ci);
            m_res = {8'h00, s8[7:0]};
            m_c   = s8[8];
            m_z   = (s8[7:0] == 8'h00);
            m_n   = s8[7];
            m_v   = (a[7] == bb[7]) && (s8[7] != a[7]);
        end
    endfunction

    // One command: request, latency/busy tracking, result and flag checks
    task automatic do_cmd(input logic [2:0] c, input logic w, input logic [15:0] a, input logic [15:0] b);
        int lat;
        int bcnt;
        int exp_lat;
        @(negedge clk);
        req = 1'b1; cmd = c; wide = w; opa = a; opb = b;
        @(posedge clk); #1;
        // Scramble inputs after capture
        req  = 1'b0;
        opa  = 16'($urandom);
        opb  = 16'($urandom);
        cmd  = 3'($urandom);
        wide = 1'($urandom);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 8) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = ((c == CLC) || (c == SEC)) ? 0 : (w ? 2 : 1);
        model_apply(c, w, a, b);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("done", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("busy_before_done", 32'(bcnt), 32'(exp_lat));
        chk("res", 32'(res), 32'(m_res));
        chk("flags_czNv", 32'({flag_c, flag_z, flag_n, flag_v}), 32'({m_c, m_z, m_n, m_v}));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int dcnt;
        logic [15:0] res_at_done;

        rst_n = 1'b0; req = 1'b0; cmd = 3'd0; wide = 1'b0; opa = 16'h0; opb = 16'h0;
        m_res = 16'h0000;
        {m_c, m_z, m_n, m_v} = STATUS_RST;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'(STATUS_RST));
        chk("rst_alu_in", 32'({alu_ai, alu_bi, alu_ci}), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_cmd(ADD, 1'b1, 16'h12FF, 16'h0001);
        chk("add16_res", 32'(res), 32'h1300);
        do_cmd(ADD, 1'b0, 16'h007F, 16'h0001);
        chk("add8_ovf", 32'({res, flag_c, flag_n, flag_v}), 32'({16'h0080, 1'b0, 1'b1, 1'b1}));
        do_cmd(SUB, 1'b0, 16'h0005, 16'h0007);
        chk("sub8_borrow", 32'({res, flag_c, flag_n, flag_v}), 32'({16'h00FE, 1'b0, 1'b1, 1'b0}));
        do_cmd(SUB, 1'b1, 16'h8000, 16'h0001);
        chk("sub16_ovf", 32'({res, flag_c, flag_z, flag_n, flag_v}), 32'({16'h7FFF, 4'b1001}));
        do_cmd(INC, 1'b1, 16'hFFFF, 16'h5A5A);
        chk("inc16_wrap", 32'({res, flag_c, flag_z}), 32'({16'h0000, 2'b11}));
        do_cmd(SEC, 1'b0, 16'h0000, 16'h0000);
        chk("sec_c", 32'(flag_c), 32'd1);
        do_cmd(ADC, 1'b0, 16'h0000, 16'h0000);
        chk("adc8_cin", 32'({res, flag_c}), 32'({16'h0001, 1'b0}));
        do_cmd(CLC, 1'b1, 16'h0000, 16'h0000);
        do_cmd(SBC, 1'b1, 16'h0100, 16'h0000);
        chk("sbc16_borrow_in", 32'({res, flag_c}), 32'({16'h00FF, 1'b1}));
        do_cmd(DEC, 1'b1, 16'h0000, 16'h0000);
        chk("dec16_zero", 32'({res, flag_c}), 32'({16'hFFFF, 1'b0}));

        // REQ held/pulsed while busy: exactly one completion
        @(negedge clk);
        req = 1'b1; cmd = ADD; wide = 1'b1; opa = 16'h4000; opb = 16'h0123;
        @(posedge clk); #1;
        cmd = SUB; opa = 16'hFFFF; opb = 16'h1111;
        dcnt = 0;
        res_at_done = 16'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                res_at_done = res;
                req = 1'b0;
            end
        end
        model_apply(ADD, 1'b1, 16'h4000, 16'h0123);
        chk("busy_req_done_count", 32'(dcnt), 32'd1);
        chk("busy_req_res", 32'(res_at_done), 32'(m_res));
        chk("busy_req_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'({m_c, m_z, m_n, m_v}));

        // Reset during the high pass aborts the command
        @(negedge clk);
        req = 1'b1; cmd = ADD; wide = 1'b1; opa = 16'hFFFF; opb = 16'hFFFF;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", 32'(res), 32'd0);
        chk("abort_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'(STATUS_RST));
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        m_res = 16'h0000;
        {m_c, m_z, m_n, m_v} = STATUS_RST;

        // Randomized command stream, with occasional extreme operands
        for (int i = 0; i < 200; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h8000;
            do_cmd(3'($urandom), 1'($urandom), ra, rb);
        end
        chk("alu_op_const", 32'(alu_op), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
